// File: rtl/axil_selftest_pkg.sv
// Shared definitions for the AXI4-Lite register self-test master.
//   - state_t / St* : FSM state encoding (localparam constants)
//   - RESP_OKAY     : AXI OKAY response code
//   - ERR_CNT_W     : width of the saturating error counter
//   - pattern()     : data word written to / expected from register index idx
package axil_selftest_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int unsigned ERR_CNT_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StWrReq  = 3'd1;
  localparam state_t StWrResp = 3'd2;
  localparam state_t StRdReq  = 3'd3;
  localparam state_t StRdData = 3'd4;
  localparam state_t StNext   = 3'd5;
  localparam state_t StFinish = 3'd6;

  // 32-bit pattern; wider data buses zero-extend it.
  function automatic logic [31:0] pattern(input logic [7:0] idx, input logic [31:0] base,
                                          input logic [31:0] step);
    return base + ({24'h0, idx} * step);
  endfunction

endpackage

// File: rtl/axil_selftest_wd.sv
// Watchdog counter for the self-test master.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   clear_i   : restart counting from zero on the next cycle
//   enable_i  : count this cycle
//   expired_o : high in the TIMEOUT_CYCLES-th consecutive enabled cycle since the last clear
module axil_selftest_wd #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  assign expired_o = enable_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/axil_reg_selftest_master.sv
// AXI4-Lite master that writes a generated pattern to NUM_REGS consecutive slave registers,
// reads them back, compares and reports pass/fail.
// Ports:
//   ACLK, ARESETN    : clock, synchronous active-low reset
//   start, mode      : start pulse; 0 = write/read per register, 1 = write all then read all
//   busy, done, pass : status (done and pass sticky until the next start)
//   err_cnt          : saturating error count
//   fail_idx         : register index of the first error
//   timeout          : sticky watchdog flag (only with AXIL_SELFTEST_TIMEOUT_EN)
//   M_AXI_*          : AXI4-Lite master channels
// Optional feature: define AXIL_SELFTEST_TIMEOUT_EN to add the per-state watchdog
// (parameter TIMEOUT_CYCLES and output timeout).
module axil_reg_selftest_master
  import axil_selftest_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS           = 4,
  parameter logic [31:0] BASE_ADDR          = 32'h0,
  parameter logic [31:0] PATTERN_BASE       = 32'h0101FFFF,
  parameter logic [31:0] PATTERN_STEP       = 32'h11111111
`ifdef AXIL_SELFTEST_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES   = 1024
`endif
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic                            mode,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [ERR_CNT_W-1:0]            err_cnt,
  output logic [7:0]                      fail_idx,
`ifdef AXIL_SELFTEST_TIMEOUT_EN
  output logic                            timeout,
`endif
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned AW           = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned BytesPerWord = C_M_AXI_DATA_WIDTH / 8;
  localparam logic [7:0]  LastIdx      = 8'(NUM_REGS - 1);

  state_t                 state_q, state_d;
  logic [7:0]             idx_q, idx_d;
  logic                   mode_q, mode_d;
  logic                   rd_phase_q, rd_phase_d;  // mode 1: write pass done, now reading
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic [7:0]             fail_q, fail_d;
  logic                   rec_err;

  logic [31:0]                   pat;
  logic [C_M_AXI_DATA_WIDTH-1:0] exp_data;
  logic [AW-1:0]                 cur_addr;

  // idx_q only moves in StNext, so address/data stay frozen while any VALID is high.
  assign pat      = pattern(idx_q, PATTERN_BASE, PATTERN_STEP);
  assign cur_addr = AW'(BASE_ADDR) + AW'(idx_q) * AW'(BytesPerWord);

  if (C_M_AXI_DATA_WIDTH == 64) begin : g_dw64
    assign exp_data = {32'h0, pat};
  end else begin : g_dw32
    assign exp_data = pat;
  end

`ifdef AXIL_SELFTEST_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic wd_active, wd_clear, wd_expired;

  assign wd_active = (state_q == StWrReq) || (state_q == StWrResp) ||
                     (state_q == StRdReq) || (state_q == StRdData);
  // Leaving a state restarts the count, so it measures time spent in one state only.
  assign wd_clear  = !wd_active || (state_d != state_q);

  axil_selftest_wd #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk_i    (ACLK),
    .rst_ni   (ARESETN),
    .clear_i  (wd_clear),
    .enable_i (wd_active),
    .expired_o(wd_expired)
  );

  assign timeout = timeout_q;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    rd_phase_d = rd_phase_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_d     = fail_q;
    rec_err    = 1'b0;
`ifdef AXIL_SELFTEST_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_d      = '0;
          fail_d     = '0;
          idx_d      = '0;
          mode_d     = mode;
          rd_phase_d = 1'b0;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = StWrReq;
`ifdef AXIL_SELFTEST_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
        end
      end
      StWrReq: begin
        // AW and W handshake independently; move on once both have completed.
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && M_AXI_WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrResp;
        end
      end
      StWrResp: begin
        if (M_AXI_BVALID) begin
          rec_err = (M_AXI_BRESP != RESP_OKAY);
          state_d = mode_q ? StNext : StRdReq;
        end
      end
      StRdReq: begin
        if (M_AXI_ARREADY) state_d = StRdData;
      end
      StRdData: begin
        if (M_AXI_RVALID) begin
          rec_err = (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != exp_data);
          state_d = StNext;
        end
      end
      StNext: begin
        if (idx_q == LastIdx) begin
          if (mode_q && !rd_phase_q) begin
            idx_d      = '0;
            rd_phase_d = 1'b1;
            state_d    = StRdReq;
          end else begin
            state_d = StFinish;
          end
        end else begin
          idx_d = idx_q + 8'd1;
          if (mode_q && rd_phase_q) begin
            state_d = StRdReq;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrReq;
          end
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rec_err) begin
      if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
      if (err_q == '0) fail_d = idx_q;
    end

`ifdef AXIL_SELFTEST_TIMEOUT_EN
    if (wd_expired) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      err_d     = '1;
      fail_d    = (err_q == '0) ? idx_q : fail_q;
      timeout_d = 1'b1;
      state_d   = StFinish;
    end
`endif
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      mode_q     <= 1'b0;
      rd_phase_q <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
`ifdef AXIL_SELFTEST_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      rd_phase_q <= rd_phase_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
`ifdef AXIL_SELFTEST_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign fail_idx      = fail_q;

  assign M_AXI_AWADDR  = cur_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = exp_data;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == StWrResp);
  assign M_AXI_ARADDR  = cur_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state_q == StRdReq);
  assign M_AXI_RREADY  = (state_q == StRdData);

endmodule

// File: tb/tb_axil_reg_selftest_master.sv
// Self-checking bench for axil_reg_selftest_master: a behavioural register slave with
// configurable ready delays and error injection, a table of directed cases, a randomized
// loop checked against a rule-level reference model, and hand-written reset/timeout sequences.
module tb_axil_reg_selftest_master;

  localparam int unsigned NREGS = 4;
  localparam logic [31:0] PBASE = 32'h0101FFFF;
  localparam logic [31:0] PSTEP = 32'h11111111;

  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        busy, done, pass;
  logic [7:0]  err_cnt, fail_idx;
`ifdef AXIL_SELFTEST_TIMEOUT_EN
  logic        timeout;
`endif
  logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic        M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = 2'b00;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;

  axil_reg_selftest_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .NUM_REGS          (NREGS),
    .BASE_ADDR         (32'h0),
    .PATTERN_BASE      (PBASE),
    .PATTERN_STEP      (PSTEP)
`ifdef AXIL_SELFTEST_TIMEOUT_EN
    , .TIMEOUT_CYCLES  (16)
`endif
  ) dut (
    .ACLK         (tb_ACLK),
    .ARESETN      (ARESETN),
    .start        (start),
    .mode         (mode),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .fail_idx     (fail_idx),
`ifdef AXIL_SELFTEST_TIMEOUT_EN
    .timeout      (timeout),
`endif
    .M_AXI_AWADDR (M_AXI_AWADDR),
    .M_AXI_AWPROT (M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA  (M_AXI_WDATA),
    .M_AXI_WSTRB  (M_AXI_WSTRB),
    .M_AXI_WVALID (M_AXI_WVALID),
    .M_AXI_WREADY (M_AXI_WREADY),
    .M_AXI_BRESP  (M_AXI_BRESP),
    .M_AXI_BVALID (M_AXI_BVALID),
    .M_AXI_BREADY (M_AXI_BREADY),
    .M_AXI_ARADDR (M_AXI_ARADDR),
    .M_AXI_ARPROT (M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA  (M_AXI_RDATA),
    .M_AXI_RRESP  (M_AXI_RRESP),
    .M_AXI_RVALID (M_AXI_RVALID),
    .M_AXI_RREADY (M_AXI_RREADY)
  );

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0, corrupt_idx = -1, bresp_idx = -1;
  bit          ar_never = 1'b0;
  int          aw_wait = 0, w_wait = 0;
  logic [31:0] mem [0:255];
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, w_first = 0, viol = 0;
  logic [31:0] wlog_addr[$], wlog_data[$];
  int          ev[$];  // 0 = AW handshake, 1 = AR handshake

  assign M_AXI_AWREADY = (aw_wait >= aw_delay);
  assign M_AXI_WREADY  = (w_wait >= w_delay);
  assign M_AXI_ARREADY = !ar_never;

  initial begin : slave
    bit          rst, awv, wv, arv, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    bit          have_aw, have_w, p_aw, p_w, p_ar;
    logic [31:0] awa, wdat, ara, aw_l, w_l, p_awa, p_wd, p_ara, prot;
    int          ai;
    have_aw = 0; have_w = 0; p_aw = 0; p_w = 0; p_ar = 0;
    aw_l = '0; w_l = '0; p_awa = '0; p_wd = '0; p_ara = '0;
    forever begin
      @(posedge tb_ACLK);
      rst   = !ARESETN;
      awv   = M_AXI_AWVALID;
      wv    = M_AXI_WVALID;
      arv   = M_AXI_ARVALID;
      aw_hs = awv && M_AXI_AWREADY;
      w_hs  = wv && M_AXI_WREADY;
      ar_hs = arv && M_AXI_ARREADY;
      b_hs  = M_AXI_BVALID && M_AXI_BREADY;
      r_hs  = M_AXI_RVALID && M_AXI_RREADY;
      awa   = M_AXI_AWADDR;
      wdat  = M_AXI_WDATA;
      ara   = M_AXI_ARADDR;
      prot  = {26'h0, M_AXI_AWPROT, M_AXI_ARPROT};
      if (!rst) begin
        // A pending VALID must persist with unchanged payload.
        if (p_aw && (!awv || awa != p_awa)) viol++;
        if (p_w && (!wv || wdat != p_wd)) viol++;
        if (p_ar && (!arv || ara != p_ara)) viol++;
        if ((awv || arv) && prot != 32'h0) viol++;
        if (wv && M_AXI_WSTRB != 4'hF) viol++;
      end
      #1;
      if (rst) begin
        M_AXI_BVALID = 1'b0;
        M_AXI_RVALID = 1'b0;
        have_aw = 0; have_w = 0; p_aw = 0; p_w = 0; p_ar = 0;
        aw_wait = 0; w_wait = 0;
      end else begin
        if (aw_hs) begin
          if (have_w) w_first++;
          have_aw = 1; aw_l = awa; aw_cnt++; ev.push_back(0);
        end
        if (w_hs) begin
          have_w = 1; w_l = wdat; w_cnt++;
        end
        if (b_hs) M_AXI_BVALID = 1'b0;
        if (have_aw && have_w) begin
          ai = int'(aw_l[9:2]);
          mem[ai] = w_l;
          wlog_addr.push_back(aw_l);
          wlog_data.push_back(w_l);
          M_AXI_BRESP  = (ai == bresp_idx) ? 2'b10 : 2'b00;
          M_AXI_BVALID = 1'b1;
          have_aw = 0; have_w = 0;
        end
        if (r_hs) M_AXI_RVALID = 1'b0;
        if (ar_hs) begin
          ai = int'(ara[9:2]);
          ar_cnt++; ev.push_back(1);
          M_AXI_RDATA  = mem[ai] ^ ((ai == corrupt_idx) ? 32'h1 : 32'h0);
          M_AXI_RRESP  = 2'b00;
          M_AXI_RVALID = 1'b1;
        end
        aw_wait = (awv && !aw_hs) ? aw_wait + 1 : 0;
        w_wait  = (wv && !w_hs) ? w_wait + 1 : 0;
        p_aw = awv && !aw_hs; p_awa = awa;
        p_w  = wv && !w_hs;   p_wd  = wdat;
        p_ar = arv && !ar_hs; p_ara = ara;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_data(input int i);
    return PBASE + PSTEP * 32'(i);
  endfunction

  // Errors in the order the test encounters them.
  function automatic void model_errs(input bit m, input int cidx, input int bidx,
                                     output logic [7:0] ec, output logic [7:0] fi);
    int seq[$];
    if (!m) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (bidx == i) seq.push_back(i);
        if (cidx == i) seq.push_back(i);
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) if (bidx == i) seq.push_back(i);
      for (int i = 0; i < int'(NREGS); i++) if (cidx == i) seq.push_back(i);
    end
    ec = 8'(seq.size());
    fi = (seq.size() > 0) ? 8'(seq[0]) : 8'd0;
  endfunction

  task automatic clear_logs();
    wlog_addr.delete(); wlog_data.delete(); ev.delete();
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; w_first = 0; viol = 0;
  endtask

  task automatic run_case(input string name, input bit m, input int awd, input int wd,
                          input int cidx, input int bidx, input bit restart,
                          input logic [7:0] exp_err, input logic [7:0] exp_fail,
                          input bit exp_pass);
    int n, na;
    bit seen_r;
    aw_delay = awd; w_delay = wd; corrupt_idx = cidx; bresp_idx = bidx;
    clear_logs();
    @(negedge tb_ACLK); mode = m; start = 1'b1;
    @(negedge tb_ACLK); start = 1'b0;
    check({name, ".busy_on"}, 32'(busy), 32'd1);
    if (restart) begin
      repeat (3) @(negedge tb_ACLK);
      mode = !m; start = 1'b1;
      @(negedge tb_ACLK); start = 1'b0;
    end
    n = 0;
    while (!done && n < 400) begin @(negedge tb_ACLK); n++; end
    check({name, ".done"}, 32'(done), 32'd1);
    check({name, ".pass"}, 32'(pass), 32'(exp_pass));
    check({name, ".err_cnt"}, 32'(err_cnt), 32'(exp_err));
    check({name, ".fail_idx"}, 32'(fail_idx), 32'(exp_fail));
    check({name, ".busy_off"}, 32'(busy), 32'd0);
    check({name, ".aw_count"}, 32'(aw_cnt), NREGS);
    check({name, ".w_count"}, 32'(w_cnt), NREGS);
    check({name, ".ar_count"}, 32'(ar_cnt), NREGS);
    check({name, ".bus_discipline"}, 32'(viol), 32'd0);
    for (int i = 0; i < int'(NREGS); i++) begin
      check($sformatf("%s.waddr%0d", name, i),
            (i < wlog_addr.size()) ? wlog_addr[i] : 32'hxxxxxxxx, 32'(4 * i));
      check($sformatf("%s.wdata%0d", name, i),
            (i < wlog_data.size()) ? wlog_data[i] : 32'hxxxxxxxx, model_data(i));
    end
    if (m) begin
      na = 0; seen_r = 0;
      foreach (ev[k]) begin
        if (ev[k] == 1) seen_r = 1;
        else if (!seen_r) na++;
      end
      check({name, ".writes_before_first_read"}, 32'(na), NREGS);
    end
    if (awd > wd) check({name, ".w_before_aw"}, 32'(w_first), NREGS);
  endtask

  typedef struct {
    string      name;
    bit         m;
    int         awd, wd, cidx, bidx;
    bit         restart;
    logic [7:0] err, fidx;
    bit         pass;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] words[4];

  initial begin
    int          n, r_m, r_awd, r_wd, r_c, r_b, r_rs;
    logic [7:0]  e_err, e_fi;

    vecs[0] = '{"m0_ready",     0, 0, 0, -1, -1, 0, 8'd0, 8'd0, 1};
    vecs[1] = '{"m1_ready",     1, 0, 0, -1, -1, 0, 8'd0, 8'd0, 1};
    vecs[2] = '{"aw_delay3",    0, 3, 0, -1, -1, 0, 8'd0, 8'd0, 1};
    vecs[3] = '{"m0_corrupt2",  0, 0, 0,  2,  3, 0, 8'd2, 8'd2, 0};
    vecs[4] = '{"m1_corrupt1",  1, 0, 0,  1,  3, 0, 8'd2, 8'd3, 0};
    vecs[5] = '{"start_ignore", 0, 1, 2, -1, -1, 1, 8'd0, 8'd0, 1};
    vecs[6] = '{"m1_wdelay",    1, 0, 3,  0, -1, 0, 8'd1, 8'd0, 0};
    words[0] = 32'h0101FFFF; words[1] = 32'h12131110;
    words[2] = 32'h23242221; words[3] = 32'h34353332;

    // Reset state
    repeat (3) @(negedge tb_ACLK);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.pass", 32'(pass), 32'd0);
    check("rst.err_cnt", 32'(err_cnt), 32'd0);
    check("rst.fail_idx", 32'(fail_idx), 32'd0);
    check("rst.handshake_outs", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                                     M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
    ARESETN = 1'b1;

    foreach (vecs[v])
      run_case(vecs[v].name, vecs[v].m, vecs[v].awd, vecs[v].wd, vecs[v].cidx, vecs[v].bidx,
               vecs[v].restart, vecs[v].err, vecs[v].fidx, vecs[v].pass);

    for (int i = 0; i < 4; i++) check($sformatf("mem%0d", i), mem[i], words[i]);

    // Randomized cases against the reference model
    for (int it = 0; it < 12; it++) begin
      r_m   = int'($urandom_range(0, 1));
      r_awd = int'($urandom_range(0, 3));
      r_wd  = int'($urandom_range(0, 3));
      r_c   = int'($urandom_range(0, 6));
      r_b   = int'($urandom_range(0, 6));
      r_rs  = int'($urandom_range(0, 1));
      model_errs(r_m[0], r_c, r_b, e_err, e_fi);
      run_case($sformatf("rand%0d", it), r_m[0], r_awd, r_wd, r_c, r_b, r_rs[0],
               e_err, e_fi, e_err == 8'd0);
    end

    // Reset during RD_DATA of index 1
    aw_delay = 0; w_delay = 0; corrupt_idx = -1; bresp_idx = -1;
    clear_logs();
    @(negedge tb_ACLK); mode = 1'b0; start = 1'b1;
    @(negedge tb_ACLK); start = 1'b0;
    n = 0;
    while (!(M_AXI_RREADY && ar_cnt == 2) && n < 100) begin @(negedge tb_ACLK); n++; end
    check("midrst.reached_rd1", 32'(M_AXI_RREADY && ar_cnt == 2), 32'd1);
    ARESETN = 1'b0;
    @(posedge tb_ACLK); #1;
    check("midrst.handshake_outs", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                                        M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    @(negedge tb_ACLK); ARESETN = 1'b1;
    run_case("post_reset", 0, 0, 0, -1, -1, 0, 8'd0, 8'd0, 1);

`ifdef AXIL_SELFTEST_TIMEOUT_EN
    // Slave never accepts AR: watchdog ends the test after 16 cycles in RD_REQ
    ar_never = 1'b1; aw_delay = 0; w_delay = 0; corrupt_idx = -1; bresp_idx = -1;
    clear_logs();
    @(negedge tb_ACLK); mode = 1'b0; start = 1'b1;
    @(negedge tb_ACLK); start = 1'b0;
    n = 0;
    while (!M_AXI_ARVALID && n < 100) begin @(negedge tb_ACLK); n++; end
    n = 0;
    while (M_AXI_ARVALID && n < 100) begin @(negedge tb_ACLK); n++; end
    check("wd.rd_req_cycles", 32'(n), 32'd16);
    n = 0;
    while (!done && n < 50) begin @(negedge tb_ACLK); n++; end
    check("wd.timeout", 32'(timeout), 32'd1);
    check("wd.err_cnt", 32'(err_cnt), 32'd255);
    check("wd.fail_idx", 32'(fail_idx), 32'd0);
    check("wd.done", 32'(done), 32'd1);
    check("wd.pass", 32'(pass), 32'd0);
    ar_never = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
